// File: rtl/dom_share_encoder_pkg.sv
// Shared definitions for the DOM gadget family: FSM states and share-port layout.
package dom_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RAND = 2'd1,
    OUTPUT    = 2'd2
  } state_e;

  localparam int unsigned SHARE0     = 32'd0;
  localparam int unsigned SHARE1     = 32'd1;
  localparam int unsigned NUM_SHARES = 32'd2;

  // Bit position of a given share of a given unmasked bit inside a packed share bus.
  function automatic int unsigned share_idx(input int unsigned bit_pos, input int unsigned share);
    return NUM_SHARES * bit_pos + share;
  endfunction

endpackage

// File: rtl/dom_share_encoder_mask_bit.sv
// One bit slice of the encoder: plaintext capture, share construction and output flops.
module dom_mask_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic plain_load,
  input  logic plain_clr,
  input  logic data_bit,
  input  logic enc_load,
  input  logic out_clr,
  input  logic mask_bit,
  input  logic refresh_bit,
  output logic share0,
  output logic share1,
  output logic refresh_out
);

  logic plain_r;
  logic share0_r;
  logic share1_r;
  logic refresh_r;

  // Plaintext holding flop, wiped as soon as it has been consumed or abandoned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plain_r <= 1'b0;
    end else if (plain_load) begin
      plain_r <= data_bit;
    end else if (plain_clr) begin
      plain_r <= 1'b0;
    end else begin
      plain_r <= plain_r;
    end
  end

  // Share and refresh flops; the single plain/mask XOR lands directly in share1_r.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      share0_r  <= 1'b0;
      share1_r  <= 1'b0;
      refresh_r <= 1'b0;
    end else if (enc_load) begin
      share0_r  <= mask_bit;
      share1_r  <= plain_r ^ mask_bit;
      refresh_r <= refresh_bit;
    end else if (out_clr) begin
      share0_r  <= 1'b0;
      share1_r  <= 1'b0;
      refresh_r <= 1'b0;
    end else begin
      share0_r  <= share0_r;
      share1_r  <= share1_r;
      refresh_r <= refresh_r;
    end
  end

  assign share0      = share0_r;
  assign share1      = share1_r;
  assign refresh_out = refresh_r;

endmodule

// File: rtl/dom_share_encoder.sv
// First-order DOM input masking stage: turns a plain word plus fresh randomness into 2 Boolean shares.
module dom_share_encoder
  import dom_pkg::*;
#(
  parameter int unsigned WIDTH        = 32'd4,
  parameter int unsigned RAND_TIMEOUT = 32'd15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 rand_req,
  input  logic [WIDTH-1:0]     rand_mask,
  input  logic [WIDTH-1:0]     rand_refresh,
  input  logic                 rand_valid,
  output logic [2*WIDTH-1:0]   out_shares,
  output logic [WIDTH-1:0]     out_r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_timeout
);

  localparam int unsigned CW       = (RAND_TIMEOUT == 32'd0) ? 32'd1 : $clog2(RAND_TIMEOUT + 32'd1);
  localparam int unsigned LAST_INT = (RAND_TIMEOUT == 32'd0) ? 32'd0 : RAND_TIMEOUT - 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam bit TIMEOUT_EN = (RAND_TIMEOUT != 32'd0);

  state_e          state_r;
  state_e          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic            in_ready_r;
  logic            rand_req_r;
  logic            out_valid_r;
  logic            err_r;
  logic            accept_s;
  logic            encode_s;
  logic            timeout_s;
  logic            handoff_s;

  // Transition decode; randomness arriving on the last wait cycle beats the timeout.
  always_comb begin
    accept_s     = 1'b0;
    encode_s     = 1'b0;
    timeout_s    = 1'b0;
    handoff_s    = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s     = 1'b1;
          state_next_s = WAIT_RAND;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_RAND: begin
        if (rand_valid) begin
          encode_s     = 1'b1;
          state_next_s = OUTPUT;
        end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_RAND;
        end
      end
      OUTPUT: begin
        if (out_valid_r && out_ready) begin
          handoff_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = OUTPUT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and handshake flags, registered from the next state so in_ready stays low through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      rand_req_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      rand_req_r  <= (state_next_s == WAIT_RAND);
      out_valid_r <= (state_next_s == OUTPUT);
      err_r       <= timeout_s;
    end
  end

  // Wait counter, saturating so a disabled timeout never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == WAIT_RAND) && !rand_valid && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic s0_s;
    logic s1_s;
    dom_mask_bit u_bit (
      .clk         (clk),
      .rst_n       (rst_n),
      .plain_load  (accept_s),
      .plain_clr   (encode_s | timeout_s),
      .data_bit    (in_data[i]),
      .enc_load    (encode_s),
      .out_clr     (handoff_s),
      .mask_bit    (rand_mask[i]),
      .refresh_bit (rand_refresh[i]),
      .share0      (s0_s),
      .share1      (s1_s),
      .refresh_out (out_r[i])
    );
    assign out_shares[share_idx(i, SHARE0)] = s0_s;
    assign out_shares[share_idx(i, SHARE1)] = s1_s;
  end

  assign in_ready    = in_ready_r;
  assign rand_req    = rand_req_r;
  assign out_valid   = out_valid_r;
  assign err_timeout = err_r;

endmodule
